dispatch: RTL

Dual-issue dispatch stage; the consumer end of the decode queue. Each cycle it examines the two head entries presented by the decoder FIFO, decides how many may issue (0, 1 or 2) under pairing and load-use rules, and pulses `invalid_en` to pop them. Issued entries, with register-file operands attached, are registered into the execute-stage input bundle.

---
 rtl/dispatch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dispatch.sv
// Dual-issue dispatch stage: pops up to two head entries from the decode queue
// under pairing/load-use rules. Define DISPATCH_DUAL_ISSUE_EN to enable slot 1.
module dispatch #(
  parameter int PC_W   = 32,
  parameter int REG_AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_pause,
  input  logic [1:0]            q_valid,
  input  logic [2*PC_W-1:0]     q_pc,
  input  logic [2*PC_W-1:0]     q_inst,
  input  logic [2*PC_W-1:0]     q_imm,
  input  logic [15:0]           q_aluop,
  input  logic [5:0]            q_alusel,
  input  logic [1:0]            q_reg1_read_en,
  input  logic [1:0]            q_reg2_read_en,
  input  logic [1:0]            q_reg_write_en,
  input  logic [2*REG_AW-1:0]   q_reg1_addr,
  input  logic [2*REG_AW-1:0]   q_reg2_addr,
  input  logic [2*REG_AW-1:0]   q_reg_write_addr,
  input  logic [1:0]            q_is_load,
  input  logic [1:0]            q_is_privilege,
  output logic [1:0]            invalid_en,
  output logic [4*REG_AW-1:0]   rf_raddr,
  input  logic [4*PC_W-1:0]     rf_rdata,
  output logic [1:0]            ex_valid,
  output logic [2*PC_W-1:0]     ex_pc,
  output logic [2*PC_W-1:0]     ex_inst,
  output logic [2*PC_W-1:0]     ex_imm,
  output logic [15:0]           ex_aluop,
  output logic [5:0]            ex_alusel,
  output logic [2*PC_W-1:0]     ex_src1,
  output logic [2*PC_W-1:0]     ex_src2,
  output logic [1:0]            ex_reg_write_en,
  output logic [2*REG_AW-1:0]   ex_reg_write_addr,
  output logic [1:0]            ex_is_load
);

`ifdef DISPATCH_DUAL_ISSUE_EN
  localparam bit LP_DUAL = 1'b1;
`else
  localparam bit LP_DUAL = 1'b0;
`endif

  logic [1:0]            r_ex_valid;
  logic [2*PC_W-1:0]     r_ex_pc;
  logic [2*PC_W-1:0]     r_ex_inst;
  logic [2*PC_W-1:0]     r_ex_imm;
  logic [15:0]           r_ex_aluop;
  logic [5:0]            r_ex_alusel;
  logic [2*PC_W-1:0]     r_ex_src1;
  logic [2*PC_W-1:0]     r_ex_src2;
  logic [1:0]            r_ex_reg_write_en;
  logic [2*REG_AW-1:0]   r_ex_reg_write_addr;
  logic [1:0]            r_ex_is_load;

  logic [REG_AW-1:0]     w_ra1 [2];
  logic [REG_AW-1:0]     w_ra2 [2];
  logic [REG_AW-1:0]     w_wa  [2];
  logic [1:0]            w_lu;
  logic [1:0]            w_issue;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_ra1[k] = q_reg1_addr[k*REG_AW +: REG_AW];
      w_ra2[k] = q_reg2_addr[k*REG_AW +: REG_AW];
      w_wa[k]  = q_reg_write_addr[k*REG_AW +: REG_AW];
    end
  end

  always_comb begin
    rf_raddr = '0;
    for (int k = 0; k < 2; k++) begin
      if (k == 0 || LP_DUAL) begin
        if (q_reg1_read_en[k]) rf_raddr[(2*k)*REG_AW +: REG_AW]   = w_ra1[k];
        if (q_reg2_read_en[k]) rf_raddr[(2*k+1)*REG_AW +: REG_AW] = w_ra2[k];
      end
    end
  end

  // A load still sitting in the ex register cannot forward yet, so any reader stalls one cycle.
  always_comb begin
    logic [REG_AW-1:0] exWa;
    w_lu = '0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        exWa = r_ex_reg_write_addr[j*REG_AW +: REG_AW];
        if (r_ex_valid[j] && r_ex_is_load[j] && r_ex_reg_write_en[j] && exWa != '0 &&
            ((q_reg1_read_en[k] && w_ra1[k] == exWa) ||
             (q_reg2_read_en[k] && w_ra2[k] == exWa)))
          w_lu[k] = 1'b1;
      end
    end
  end

  assign w_issue[0] = q_valid[0] && !ex_pause && !flush && !rst && !w_lu[0];

`ifdef DISPATCH_DUAL_ISSUE_EN
  logic w_raw;
  logic w_waw;

  assign w_raw = q_reg_write_en[0] && (w_wa[0] != '0) &&
                 ((q_reg1_read_en[1] && w_ra1[1] == w_wa[0]) ||
                  (q_reg2_read_en[1] && w_ra2[1] == w_wa[0]));
  assign w_waw = q_reg_write_en[0] && q_reg_write_en[1] &&
                 (w_wa[0] != '0) && (w_wa[0] == w_wa[1]);
  assign w_issue[1] = w_issue[0] && q_valid[1] && !(|q_is_privilege) &&
                      !w_lu[1] && !w_raw && !w_waw;
`else
  logic w_unused;
  assign w_unused   = &{1'b0, q_valid[1], q_is_privilege, w_lu[1]};
  assign w_issue[1] = 1'b0;
`endif

  assign invalid_en = w_issue;

  // Non-issued slots load zeros so a bubble carries no stale fields.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ex_valid          <= '0;
      r_ex_pc             <= '0;
      r_ex_inst           <= '0;
      r_ex_imm            <= '0;
      r_ex_aluop          <= '0;
      r_ex_alusel         <= '0;
      r_ex_src1           <= '0;
      r_ex_src2           <= '0;
      r_ex_reg_write_en   <= '0;
      r_ex_reg_write_addr <= '0;
      r_ex_is_load        <= '0;
    end else if (!ex_pause) begin
      for (int k = 0; k < 2; k++) begin
        r_ex_valid[k] <= w_issue[k];
        if (w_issue[k]) begin
          r_ex_pc[k*PC_W +: PC_W]               <= q_pc[k*PC_W +: PC_W];
          r_ex_inst[k*PC_W +: PC_W]             <= q_inst[k*PC_W +: PC_W];
          r_ex_imm[k*PC_W +: PC_W]              <= q_imm[k*PC_W +: PC_W];
          r_ex_aluop[k*8 +: 8]                  <= q_aluop[k*8 +: 8];
          r_ex_alusel[k*3 +: 3]                 <= q_alusel[k*3 +: 3];
          r_ex_src1[k*PC_W +: PC_W]             <= q_reg1_read_en[k] ? rf_rdata[(2*k)*PC_W +: PC_W] : '0;
          r_ex_src2[k*PC_W +: PC_W]             <= q_reg2_read_en[k] ? rf_rdata[(2*k+1)*PC_W +: PC_W] : '0;
          r_ex_reg_write_en[k]                  <= q_reg_write_en[k];
          r_ex_reg_write_addr[k*REG_AW +: REG_AW] <= w_wa[k];
          r_ex_is_load[k]                       <= q_is_load[k];
        end else begin
          r_ex_pc[k*PC_W +: PC_W]               <= '0;
          r_ex_inst[k*PC_W +: PC_W]             <= '0;
          r_ex_imm[k*PC_W +: PC_W]              <= '0;
          r_ex_aluop[k*8 +: 8]                  <= '0;
          r_ex_alusel[k*3 +: 3]                 <= '0;
          r_ex_src1[k*PC_W +: PC_W]             <= '0;
          r_ex_src2[k*PC_W +: PC_W]             <= '0;
          r_ex_reg_write_en[k]                  <= 1'b0;
          r_ex_reg_write_addr[k*REG_AW +: REG_AW] <= '0;
          r_ex_is_load[k]                       <= 1'b0;
        end
      end
    end
  end

  assign ex_valid          = r_ex_valid;
  assign ex_pc             = r_ex_pc;
  assign ex_inst           = r_ex_inst;
  assign ex_imm            = r_ex_imm;
  assign ex_aluop          = r_ex_aluop;
  assign ex_alusel         = r_ex_alusel;
  assign ex_src1           = r_ex_src1;
  assign ex_src2           = r_ex_src2;
  assign ex_reg_write_en   = r_ex_reg_write_en;
  assign ex_reg_write_addr = r_ex_reg_write_addr;
  assign ex_is_load        = r_ex_is_load;

endmodule
